// File: rtl/dct_pkg.sv
// Shared lane geometry and signed clamp helper for the pipelined
// 8-point DCT stage-4 butterfly.
package dct_pkg;

   localparam int DCT_LANES = 8;
   localparam int L0 = 0;
   localparam int L1 = 1;
   localparam int L2 = 2;
   localparam int L3 = 3;
   localparam int L4 = 4;
   localparam int L5 = 5;
   localparam int L6 = 6;
   localparam int L7 = 7;

   // Extra bits on top of LANE_W+SHIFT so that x<<S - d<<S never overflows.
   localparam int WIDE_GUARD = 3;
   // Carrier width for sat_to_w; must cover LANE_W+SHIFT+WIDE_GUARD.
   localparam int MAX_WIDE_W = 128;

   function automatic logic signed [MAX_WIDE_W-1:0] sat_to_w(
      input logic signed [MAX_WIDE_W-1:0] value,
      input int                           width
   );
      logic signed [MAX_WIDE_W-1:0] hi;
      logic signed [MAX_WIDE_W-1:0] lo;
      hi = (MAX_WIDE_W'(1) << (width - 1)) - MAX_WIDE_W'(1);
      lo = ~hi;
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      else
         return value;
   endfunction

endpackage

// File: rtl/dct_8_stage_4_pipe_stage.sv
// One valid/ready register slice; accepts whenever it is empty or its
// consumer is draining it in the same cycle.
module dct_elastic_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   logic         vld;
   logic [W-1:0] data;

   assign up_ready = !vld || dn_ready;
   assign dn_valid = vld;
   assign dn_data  = data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld  <= 1'b0;
         data <= '0;
      end else if (up_ready) begin
         vld <= up_valid;
         if (up_valid)
            data <= up_data;
      end
   end

endmodule

// File: rtl/dct_8_stage_4_pipe.sv
// Two-slice elastic DCT stage-4 butterfly: slice A holds {sat, x6-x4, x},
// slice B holds the finished lanes and drives the outputs directly.
module dct_8_stage_4_pipe
   import dct_pkg::*;
#(
   parameter int LANE_W = 64,
   parameter int SHIFT  = 4,
   parameter int CNT_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DCT_LANES*LANE_W-1:0] i_data_in,
   input  logic                        i_valid,
   output logic                        i_ready,
   input  logic                        cfg_sat,
   output logic [DCT_LANES*LANE_W-1:0] o_data_out,
   output logic                        o_valid,
   input  logic                        o_ready,
   output logic [CNT_W-1:0]            o_beat_cnt
);

   localparam int VEC_W  = DCT_LANES * LANE_W;
   localparam int D_W    = LANE_W + 1;
   localparam int A_W    = VEC_W + D_W + 1;
   localparam int WIDE_W = LANE_W + SHIFT + WIDE_GUARD;

   // Handshake: a beat moves across a boundary on the rising edge where
   // valid && ready are both high; valid never depends on ready, and a
   // slice is ready when empty or when its own beat leaves that same edge.
   logic                     ready_a;
   logic                     ready_b;
   logic                     valid_a;
   logic [A_W-1:0]           a_in;
   logic [A_W-1:0]           a_q;
   logic signed [D_W-1:0]    d_in;
   logic [VEC_W-1:0]         a_x;
   logic signed [D_W-1:0]    a_d;
   logic                     a_sat;
   logic [VEC_W-1:0]         b_in;
   logic signed [WIDE_W-1:0] x4_w;
   logic signed [WIDE_W-1:0] x6_w;
   logic signed [WIDE_W-1:0] d_w;
   logic signed [WIDE_W-1:0] w2;
   logic signed [WIDE_W-1:0] w4;
   logic signed [WIDE_W-1:0] w5;
   logic signed [WIDE_W-1:0] w6;

   // Low LANE_W bits of the exact result are the modulo answer; saturation
   // only differs when the exact result leaves the signed lane range.
   function automatic logic [LANE_W-1:0] finish_lane(
      input logic signed [WIDE_W-1:0] v,
      input logic                     sat
   );
      logic signed [MAX_WIDE_W-1:0] c;
      c = sat_to_w(MAX_WIDE_W'(v), LANE_W);
      return sat ? c[LANE_W-1:0] : v[LANE_W-1:0];
   endfunction

   always_comb begin
      d_in = D_W'(signed'(i_data_in[L6*LANE_W +: LANE_W]))
           - D_W'(signed'(i_data_in[L4*LANE_W +: LANE_W]));
      a_in = {cfg_sat, d_in, i_data_in};
   end

   assign i_ready = ready_a && !rst;

   dct_elastic_stage #(.W(A_W)) u_stage_a (
      .clk      (clk),
      .rst      (rst),
      .up_valid (i_valid),
      .up_ready (ready_a),
      .up_data  (a_in),
      .dn_valid (valid_a),
      .dn_ready (ready_b),
      .dn_data  (a_q)
   );

   assign a_x   = a_q[VEC_W-1:0];
   assign a_d   = a_q[VEC_W +: D_W];
   assign a_sat = a_q[A_W-1];

   always_comb begin
      x4_w = WIDE_W'(signed'(a_x[L4*LANE_W +: LANE_W]));
      x6_w = WIDE_W'(signed'(a_x[L6*LANE_W +: LANE_W]));
      d_w  = WIDE_W'(a_d);
      w2   = WIDE_W'(signed'(a_x[L2*LANE_W +: LANE_W])) <<< SHIFT;
      w5   = WIDE_W'(signed'(a_x[L5*LANE_W +: LANE_W])) <<< SHIFT;
      w4   = (x4_w <<< SHIFT) - (d_w <<< SHIFT);
      w6   = (x6_w <<< SHIFT) - (d_w <<< SHIFT);
      b_in = a_x;
      b_in[L2*LANE_W +: LANE_W] = finish_lane(w2, a_sat);
      b_in[L4*LANE_W +: LANE_W] = finish_lane(w4, a_sat);
      b_in[L5*LANE_W +: LANE_W] = finish_lane(w5, a_sat);
      b_in[L6*LANE_W +: LANE_W] = finish_lane(w6, a_sat);
   end

   dct_elastic_stage #(.W(VEC_W)) u_stage_b (
      .clk      (clk),
      .rst      (rst),
      .up_valid (valid_a),
      .up_ready (ready_b),
      .up_data  (b_in),
      .dn_valid (o_valid),
      .dn_ready (o_ready),
      .dn_data  (o_data_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         o_beat_cnt <= '0;
      else if (o_valid && o_ready)
         o_beat_cnt <= o_beat_cnt + CNT_W'(1);
   end

endmodule
